// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared types and run-rate table for the CPU clock-enable controller.
package cpu_clk_ctrl_pkg;

    typedef enum logic {HALT = 1'b0, RUN = 1'b1} ctrl_state_t;

    localparam int unsigned RATE_CNT_W = 25;
    localparam int unsigned RATE_DIV [4] = '{32'd64, 32'd1048576, 32'd8388608, 32'd33554432};

    // Terminal count for the selected rate (period of DIV cycles).
    function automatic logic [RATE_CNT_W-1:0] rate_limit(input logic [1:0] sel);
        return RATE_CNT_W'(RATE_DIV[sel] - 32'd1);
    endfunction

endpackage

// File: rtl/cpu_clk_ctrl_debounce.sv
// Two-flop synchronizer plus stable-level debouncer for one raw input bit.
module debounce #(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter logic        RST_VAL    = 1'b0
) (
    input  logic CLOCK_50,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            sync1 <= RST_VAL;
            sync2 <= RST_VAL;
            dout  <= RST_VAL;
            cnt   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 == dout) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                dout <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Clock-enable controller for the single-cycle CPU: RUN (periodic) or HALT (single-step).
// Optional auto-repeat while the step key is held: define HOLD_REPEAT_EN.
module cpu_clk_ctrl
    import cpu_clk_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = 500000,
    parameter int unsigned CE_CNT_W      = 16,
    parameter int unsigned REPEAT_CYCLES = 12500000
) (
    input  logic                CLOCK_50,
    input  logic                rst,
    input  logic                key_step_n,
    input  logic                sw_run,
    input  logic [1:0]          sw_rate,
    output logic                cpu_ce,
    output logic                run_mode,
    output logic [CE_CNT_W-1:0] ce_count
);
    if (DEB_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
        $error("cpu_clk_ctrl: DEB_CYCLES and REPEAT_CYCLES must be at least 2");
    end

    logic                  key_db;
    logic                  run_db;
    logic [1:0]            rate_db;
    logic                  key_prev;
    logic                  press;
    ctrl_state_t           state;
    ctrl_state_t           next_state;
    logic [RATE_CNT_W-1:0] rate_cnt;
    logic [RATE_CNT_W-1:0] rate_cnt_next;
    logic                  ce_next;

    debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_db_key (
        .CLOCK_50(CLOCK_50), .rst(rst), .din(key_step_n), .dout(key_db));
    debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_db_run (
        .CLOCK_50(CLOCK_50), .rst(rst), .din(sw_run), .dout(run_db));
    debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_db_rate0 (
        .CLOCK_50(CLOCK_50), .rst(rst), .din(sw_rate[0]), .dout(rate_db[0]));
    debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_db_rate1 (
        .CLOCK_50(CLOCK_50), .rst(rst), .din(sw_rate[1]), .dout(rate_db[1]));

    assign press = key_prev & ~key_db;

`ifdef HOLD_REPEAT_EN
    localparam int unsigned REP_CNT_W = $clog2(REPEAT_CYCLES);
    logic [REP_CNT_W-1:0] rep_cnt;
    logic [REP_CNT_W-1:0] rep_cnt_next;
    logic                 rep_arm;
    logic                 rep_arm_next;
`endif

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state <= HALT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            HALT:    if (run_db)  next_state = RUN;
            RUN:     if (!run_db) next_state = HALT;
            default: next_state = HALT;
        endcase
    end

    // A mode change in this cycle suppresses both the rate pulse and any step press.
    always_comb begin
        ce_next       = 1'b0;
        rate_cnt_next = '0;
`ifdef HOLD_REPEAT_EN
        rep_cnt_next  = '0;
        rep_arm_next  = 1'b0;
`endif
        unique case (state)
            HALT: begin
                if (next_state == HALT) begin
                    if (press) begin
                        ce_next = 1'b1;
`ifdef HOLD_REPEAT_EN
                        rep_arm_next = 1'b1;
                    end else if (rep_arm && !key_db) begin
                        rep_arm_next = 1'b1;
                        if (rep_cnt >= REP_CNT_W'(REPEAT_CYCLES - 1)) begin
                            ce_next = 1'b1;
                        end else begin
                            rep_cnt_next = rep_cnt + REP_CNT_W'(1);
                        end
`endif
                    end
                end
            end
            RUN: begin
                if (next_state == RUN) begin
                    if (rate_cnt >= rate_limit(rate_db)) begin
                        ce_next = 1'b1;
                    end else begin
                        rate_cnt_next = rate_cnt + RATE_CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            key_prev <= 1'b1;
            rate_cnt <= '0;
            cpu_ce   <= 1'b0;
            ce_count <= '0;
`ifdef HOLD_REPEAT_EN
            rep_cnt  <= '0;
            rep_arm  <= 1'b0;
`endif
        end else begin
            key_prev <= key_db;
            rate_cnt <= rate_cnt_next;
            cpu_ce   <= ce_next;
            if (ce_next) begin
                ce_count <= ce_count + CE_CNT_W'(1);
            end
`ifdef HOLD_REPEAT_EN
            rep_cnt  <= rep_cnt_next;
            rep_arm  <= rep_arm_next;
`endif
        end
    end

    assign run_mode = state;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl with DEB_CYCLES=8, REPEAT_CYCLES=40.
module tb_cpu_clk_ctrl;

    localparam int unsigned CW = 16;

    logic          CLOCK_50 = 1'b0;
    logic          rst;
    logic          key_step_n;
    logic          sw_run;
    logic [1:0]    sw_rate;
    logic          cpu_ce;
    logic          run_mode;
    logic [CW-1:0] ce_count;

    cpu_clk_ctrl #(.DEB_CYCLES(8), .CE_CNT_W(CW), .REPEAT_CYCLES(40)) dut (
        .CLOCK_50(CLOCK_50), .rst(rst), .key_step_n(key_step_n), .sw_run(sw_run),
        .sw_rate(sw_rate), .cpu_ce(cpu_ce), .run_mode(run_mode), .ce_count(ce_count));

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic       key;
        logic       run;
        logic [1:0] rate;
        int         cycles;
        int         exp_pulses;
        logic       exp_run;
        int         exp_cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   npulse, first_pulse, first_run, first_halt, gap_err, after_halt;
    int   adj_err  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance n cycles, sampling 1 time unit after each rising edge.
    task automatic run_cycles(input int n, input int exp_gap);
        int   last;
        logic prev_ce;
        npulse = 0; first_pulse = -1; first_run = -1; first_halt = -1;
        gap_err = 0; after_halt = 0; last = -1; prev_ce = cpu_ce;
        for (int i = 1; i <= n; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (run_mode === 1'b1 && first_run < 0)  first_run = i;
            if (run_mode !== 1'b1 && first_halt < 0) first_halt = i;
            if (cpu_ce === 1'b1) begin
                npulse++;
                if (first_pulse < 0) first_pulse = i;
                if (prev_ce === 1'b1) adj_err++;
                if (exp_gap > 0 && last >= 0 && (i - last) != exp_gap) gap_err++;
                if (first_halt > 0) after_halt++;
                last = i;
            end
            prev_ce = cpu_ce;
        end
    endtask

    task automatic apply_table(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            key_step_n = tbl[k].key;
            sw_run     = tbl[k].run;
            sw_rate    = tbl[k].rate;
            run_cycles(tbl[k].cycles, 0);
            check($sformatf("vec%0d pulses", k), npulse, tbl[k].exp_pulses);
            check($sformatf("vec%0d run_mode", k), run_mode, tbl[k].exp_run);
            check($sformatf("vec%0d ce_count", k), ce_count, tbl[k].exp_cnt);
        end
    endtask

    initial begin
        // 0..19: short key glitches in HALT are ignored
        for (int g = 0; g < 10; g++) begin
            tbl.push_back('{1'b0, 1'b0, 2'd0, 5, 0, 1'b0, 1});
            tbl.push_back('{1'b1, 1'b0, 2'd0, 5, 0, 1'b0, 1});
        end
        // 20: slowest rate in RUN, no pulse within 200 cycles
        tbl.push_back('{1'b1, 1'b1, 2'd3, 200, 0, 1'b1, 16});
        // 21: key release in HALT after the discarded press
        tbl.push_back('{1'b1, 1'b0, 2'd0, 20, 0, 1'b0, 20});

        rst = 1'b1; key_step_n = 1'b1; sw_run = 1'b0; sw_rate = 2'd0;
        run_cycles(3, 0);
        check("reset cpu_ce", cpu_ce, 0);
        check("reset run_mode", run_mode, 0);
        check("reset ce_count", ce_count, 0);
        rst = 1'b0;
        run_cycles(5, 0);
        check("idle pulses", npulse, 0);

        // Single step: pulse DEB_CYCLES+3 edges after the drop
        key_step_n = 1'b0;
        run_cycles(20, 0);
        check("step latency", first_pulse, 11);
        check("step pulses", npulse, 1);
        check("step ce_count", ce_count, 1);
        key_step_n = 1'b1;
        run_cycles(20, 0);
        check("release pulses", npulse, 0);

        apply_table(0, 19);

        // RUN at rate 0
        sw_run = 1'b1; sw_rate = 2'd0;
        run_cycles(1000, 64);
        check("run entry edge", first_run, 11);
        check("run first pulse", first_pulse, 75);
        check("run pulses", npulse, 15);
        check("run spacing", gap_err, 0);
        check("run ce_count", ce_count, 16);

        apply_table(20, 20);

        // Mid-count rate decrease fires right after the new rate settles
        sw_rate = 2'd0;
        run_cycles(200, 64);
        check("rate drop first", first_pulse, 11);
        check("rate drop pulses", npulse, 3);
        check("rate drop spacing", gap_err, 0);
        check("rate drop ce_count", ce_count, 19);

        // Mode change and step press together: press discarded
        sw_run = 1'b0; key_step_n = 1'b0;
        run_cycles(40, 0);
        check("halt edge", first_halt, 11);
        check("pulse before halt", first_pulse, 3);
        check("pulses after halt", after_halt, 0);
        check("halt ce_count", ce_count, 20);

        apply_table(21, 21);

        // Reset 10 cycles before a RUN pulse
        sw_run = 1'b1;
        run_cycles(65, 0);
        check("rerun entry edge", first_run, 11);
        check("rerun pulses", npulse, 0);
        rst = 1'b1;
        run_cycles(15, 0);
        check("rst pulses", npulse, 0);
        check("rst run seen", first_run, -1);
        check("rst cpu_ce", cpu_ce, 0);
        check("rst ce_count", ce_count, 0);
        rst = 1'b0;
        run_cycles(20, 0);
        check("post-rst run edge", first_run, 11);
        check("post-rst pulses", npulse, 0);
        check("post-rst ce_count", ce_count, 0);

        check("adjacent pulses", adj_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
